// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing one host SD block port between NUM_REQ sector clients.
// Define SD_ARB_FIXED_PRIORITY_EN for fixed priority (lowest pending index always wins).
module sd_block_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int LBA_W          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_rd,
  input  logic [NUM_REQ-1:0]       req_wr,
  input  logic [NUM_REQ*LBA_W-1:0] req_lba,
  input  logic [NUM_REQ*8-1:0]     req_buff_din,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [LBA_W-1:0]         host_lba,
  output logic                     host_rd,
  output logic                     host_wr,
  input  logic                     host_ack,
  output logic [7:0]               host_buff_din,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_RELEASE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [LBA_W-1:0]     lba_q, lba_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_q, ack_d;

  logic [NUM_REQ-1:0]   pending;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic                 ack_rise;
  logic                 ack_fall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Search starts just after the last served client so a re-requesting client waits its turn.
  always_comb begin
    int j;
    j        = 0;
    pending  = req_rd | req_wr;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SD_ARB_FIXED_PRIORITY_EN
      j = k;
`else
      j = int'(last_q) + 1 + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
`endif
      if (!pick_vld && pending[j]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  assign ack_rise = host_ack & ~ack_q;
  assign ack_fall = ~host_ack & ack_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    ack_d     = host_ack;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d           = S_ISSUE;
          idx_d             = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          lba_d             = req_lba[int'(pick_idx)*LBA_W +: LBA_W];
          rd_d              = req_rd[pick_idx];
          wr_d              = ~req_rd[pick_idx] & req_wr[pick_idx];
          cnt_d             = '0;
        end
      end
      S_ISSUE: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_d = sat_inc(cnt_q);
          // Abort without acking the client; it simply competes again later.
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            rd_d      = 1'b0;
            wr_d      = 1'b0;
            timeout_d = 1'b1;
            grant_d   = '0;
            last_d    = idx_q;
            state_d   = S_RELEASE;
          end
        end
      end
      S_XFER: begin
        if (ack_fall) begin
          grant_d = '0;
          last_d  = idx_q;
          state_d = S_RELEASE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    host_buff_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) host_buff_din = req_buff_din[i*8 +: 8];
    end
  end

  assign req_ack  = grant_q & {NUM_REQ{host_ack}};
  assign host_lba = lba_q;
  assign host_rd  = rd_q;
  assign host_wr  = wr_q;
  assign grant    = grant_q;
  assign busy     = (state_q != S_IDLE);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter (round-robin build, 16-cycle watchdog).
module tb_sd_block_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req_rd;
  logic [2:0]  req_wr;
  logic [95:0] req_lba;
  logic [23:0] req_buff_din;
  logic [2:0]  req_ack;
  logic [31:0] host_lba;
  logic        host_rd;
  logic        host_wr;
  logic        host_ack;
  logic [7:0]  host_buff_din;
  logic [2:0]  grant;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  sd_block_arbiter #(.NUM_REQ(3), .LBA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .req_buff_din(req_buff_din), .req_ack(req_ack), .host_lba(host_lba), .host_rd(host_rd),
    .host_wr(host_wr), .host_ack(host_ack), .host_buff_din(host_buff_din), .grant(grant),
    .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; req_lba = '0; req_buff_din = '0; host_ack = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  // Host acks for 'hold' cycles; clients in 'drop' release their request once acked.
  task automatic serve(input logic [2:0] drop, input int hold);
    host_ack = 1'b1;
    step(1);
    req_rd = req_rd & ~drop;
    req_wr = req_wr & ~drop;
    step(hold - 1);
    host_ack = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; req_lba = '0; req_buff_din = '0; host_ack = 1'b1;
    #3;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b exp 000", grant); end
    checks++; if ({host_rd, host_wr, timeout, busy} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {host_rd, host_wr, timeout, busy}); end
    checks++; if (host_lba !== 32'h0) begin errors++; $display("FAIL reset_lba got %h exp 0", host_lba); end
    checks++; if (req_ack !== 3'b000) begin errors++; $display("FAIL reset_req_ack got %b exp 000", req_ack); end
    host_ack = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_rd = 3'b001;
    req_lba[31:0] = 32'h10;
    step(1);
    checks++; if ({host_rd, host_wr} !== 2'b10) begin errors++; $display("FAIL single_strobe got %b exp 10", {host_rd, host_wr}); end
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant got %b exp 001", grant); end
    checks++; if (host_lba !== 32'h10) begin errors++; $display("FAIL single_lba got %h exp 10", host_lba); end
    checks++; if (req_ack !== 3'b000) begin errors++; $display("FAIL single_ack_early got %b exp 000", req_ack); end
    step(4);
    host_ack = 1'b1;
    #1;
    checks++; if (req_ack !== 3'b001) begin errors++; $display("FAIL single_ack_mirror got %b exp 001", req_ack); end
    step(1);
    req_rd = 3'b000;
    checks++; if (host_rd !== 1'b0) begin errors++; $display("FAIL single_rd_clear got %b exp 0", host_rd); end
    step(510);
    checks++; if ({busy, grant, req_ack} !== 7'b1001001) begin errors++; $display("FAIL single_hold got %b exp 1001001", {busy, grant, req_ack}); end
    step(1);
    host_ack = 1'b0;
    #1;
    checks++; if (req_ack !== 3'b000) begin errors++; $display("FAIL single_ack_fall got %b exp 000", req_ack); end
    step(1);
    checks++; if ({busy, grant} !== 4'b1000) begin errors++; $display("FAIL single_release got %b exp 1000", {busy, grant}); end
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
  endtask

  task automatic test_two_clients();
    do_reset();
    req_lba[31:0] = 32'h100;
    req_lba[95:64] = 32'h300;
    req_rd = 3'b101;
    step(1);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL two_first_grant got %b exp 001", grant); end
    checks++; if (host_lba !== 32'h100) begin errors++; $display("FAIL two_first_lba got %h exp 100", host_lba); end
    serve(3'b001, 3);
    step(1);
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL two_second_grant got %b exp 100", grant); end
    checks++; if ({host_lba, host_rd} !== {32'h300, 1'b1}) begin errors++; $display("FAIL two_second_lba got %h/%b exp 300/1", host_lba, host_rd); end
    serve(3'b100, 3);
    step(1);
    checks++; if ({busy, grant} !== 4'b0000) begin errors++; $display("FAIL two_done got %b exp 0000", {busy, grant}); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_order [4];
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    req_rd = 3'b111;
    for (int n = 0; n < 4; n++) begin
      step(1);
      checks++; if (grant !== exp_order[n]) begin errors++; $display("FAIL rr_grant_%0d got %b exp %b", n, grant, exp_order[n]); end
      serve((n == 3) ? 3'b111 : 3'b000, 4);
    end
  endtask

  task automatic test_direction();
    do_reset();
    req_buff_din = 24'h22_5A_11;
    req_lba[63:32] = 32'h2A;
    req_rd = 3'b010;
    req_wr = 3'b010;
    #1;
    checks++; if (host_buff_din !== 8'h00) begin errors++; $display("FAIL dir_buff_idle got %h exp 00", host_buff_din); end
    step(1);
    checks++; if ({host_rd, host_wr} !== 2'b10) begin errors++; $display("FAIL dir_rd_wins got %b exp 10", {host_rd, host_wr}); end
    checks++; if ({grant, host_lba} !== {3'b010, 32'h2A}) begin errors++; $display("FAIL dir_grant_lba got %b/%h exp 010/2a", grant, host_lba); end
    checks++; if (host_buff_din !== 8'h5A) begin errors++; $display("FAIL dir_buff got %h exp 5a", host_buff_din); end
    serve(3'b010, 3);
    req_wr = 3'b100;
    step(1);
    checks++; if ({grant, host_rd, host_wr} !== 5'b10001) begin errors++; $display("FAIL dir_wr_only got %b exp 10001", {grant, host_rd, host_wr}); end
    checks++; if (host_buff_din !== 8'h22) begin errors++; $display("FAIL dir_buff2 got %h exp 22", host_buff_din); end
    serve(3'b100, 2);
    checks++; if (host_buff_din !== 8'h00) begin errors++; $display("FAIL dir_buff_after got %h exp 00", host_buff_din); end
  endtask

  task automatic test_timeout();
    do_reset();
    req_rd = 3'b011;
    step(1);
    checks++; if ({grant, host_rd} !== 4'b0011) begin errors++; $display("FAIL to_issue got %b exp 0011", {grant, host_rd}); end
    step(15);
    checks++; if ({host_rd, timeout} !== 2'b10) begin errors++; $display("FAIL to_before got %b exp 10", {host_rd, timeout}); end
    step(1);
    checks++; if ({host_rd, timeout, grant, busy} !== 6'b010001) begin errors++; $display("FAIL to_abort got %b exp 010001", {host_rd, timeout, grant, busy}); end
    step(1);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %b exp 0", timeout); end
    step(1);
    checks++; if ({grant, host_rd} !== 4'b0101) begin errors++; $display("FAIL to_next_grant got %b exp 0101", {grant, host_rd}); end
    host_ack = 1'b0;
  endtask

  task automatic test_ack_in_idle();
    do_reset();
    host_ack = 1'b1;
    step(2);
    checks++; if ({req_ack, busy, host_rd} !== 5'b00000) begin errors++; $display("FAIL idle_ack got %b exp 00000", {req_ack, busy, host_rd}); end
    host_ack = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    do_reset();
    req_rd = 3'b001;
    step(1);
    serve(3'b001, 2);
    req_rd = 3'b010;
    step(1);
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL mid_grant got %b exp 010", grant); end
    host_ack = 1'b1;
    step(1);
    checks++; if (req_ack !== 3'b010) begin errors++; $display("FAIL mid_req_ack got %b exp 010", req_ack); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({grant, req_ack, host_rd, host_wr, busy} !== 9'b0) begin errors++; $display("FAIL mid_async got %b exp 000000000", {grant, req_ack, host_rd, host_wr, busy}); end
    host_ack = 1'b0;
    req_rd = 3'b101;
    reset_n = 1'b1;
    step(1);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL mid_first_prio got %b exp 001", grant); end
    serve(3'b101, 2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_clients();
    test_round_robin();
    test_direction();
    test_timeout();
    test_ack_in_idle();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
